alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 54 +++++
 rtl/alu_arbiter.sv | 99 +++++++++
 tb/tb_alu_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals of the two-requester ALU arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface alu_arbiter_if #(
    parameter int reglength = 4
);
    logic                 req0_valid;
    logic                 req1_valid;
    logic                 req0_ready;
    logic                 req1_ready;
    logic [2:0]           req0_op;
    logic [2:0]           req1_op;
    logic [reglength-1:0] req0_a;
    logic [reglength-1:0] req0_b;
    logic [reglength-1:0] req1_a;
    logic [reglength-1:0] req1_b;
    logic                 req0_s;
    logic                 req1_s;

    logic [2:0]           alu_control;
    logic [reglength-1:0] alu_srca;
    logic [reglength-1:0] alu_srcb;
    logic [reglength-1:0] alu_result;
    logic                 alu_n;
    logic                 alu_z;
    logic                 alu_co;
    logic                 alu_ovf;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [reglength-1:0] rsp_result;
    logic [3:0]           rsp_flags;
    logic [3:0]           flags;

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op,
        input  req0_a, req0_b, req1_a, req1_b, req0_s, req1_s,
        output req0_ready, req1_ready,
        output alu_control, alu_srca, alu_srcb,
        input  alu_result, alu_n, alu_z, alu_co, alu_ovf,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, flags,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op,
        output req0_a, req0_b, req1_a, req1_b, req0_s, req1_s,
        input  req0_ready, req1_ready,
        input  alu_control, alu_srca, alu_srcb,
        output alu_result, alu_n, alu_z, alu_co, alu_ovf,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, flags,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with an NZCV flag register and a valid/ready response channel.
module alu_arbiter #(
    parameter int reglength = 4
) (
    input  logic           clk,
    input  logic           reset,
    alu_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t               state;
    logic                 last_grant;
    logic                 grant_id;
    logic                 any_valid;
    logic                 cur_id;
    logic                 s_q;
    logic [2:0]           op_q;
    logic [reglength-1:0] a_q;
    logic [reglength-1:0] b_q;
    logic                 rsp_valid_q;
    logic                 rsp_id_q;
    logic [reglength-1:0] rsp_result_q;
    logic [3:0]           rsp_flags_q;
    logic [3:0]           flags_q;
    logic                 arith;
    logic [3:0]           nzcv;

    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            grant_id = ~last_grant;
        else
            grant_id = bus.req1_valid;
        // C and V only mean something for the adder ops; logic ops keep them.
        arith = (op_q <= 3'b010);
        nzcv  = {bus.alu_n, bus.alu_z,
                 arith ? bus.alu_co  : flags_q[1],
                 arith ? bus.alu_ovf : flags_q[0]};
    end

    assign bus.req0_ready  = (state == IDLE) && !reset && bus.req0_valid && !grant_id;
    assign bus.req1_ready  = (state == IDLE) && !reset && bus.req1_valid &&  grant_id;
    assign bus.alu_control = op_q;
    assign bus.alu_srca    = a_q;
    assign bus.alu_srcb    = b_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_flags   = rsp_flags_q;
    assign bus.flags       = flags_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            cur_id       <= 1'b0;
            s_q          <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            flags_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_q       <= grant_id ? bus.req1_op : bus.req0_op;
                        a_q        <= grant_id ? bus.req1_a  : bus.req0_a;
                        b_q        <= grant_id ? bus.req1_b  : bus.req0_b;
                        s_q        <= grant_id ? bus.req1_s  : bus.req0_s;
                        cur_id     <= grant_id;
                        last_grant <= grant_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_q <= bus.alu_result;
                    rsp_flags_q  <= nzcv;
                    rsp_id_q     <= cur_id;
                    rsp_valid_q  <= 1'b1;
                    if (s_q)
                        flags_q <= nzcv;
                    state <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: the bench supplies the shared ALU and
// predicts each response and the flag register at accept time.
module tb_alu_arbiter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_arbiter_if #(.reglength(W)) bus ();
    alu_arbiter #(.reglength(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns {result[3:0], n, z, c, v}; logic ops report c=v=1 so any
    // failure to retain the old C/V shows up.
    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic [4:0] t;
        logic       c, v;
        c = 1'b1;
        v = 1'b1;
        t = '0;
        case (op)
            3'd0: begin t = {1'b0, a} + {1'b0, b};         v = (a[3] == b[3]) && (t[3] != a[3]); end
            3'd1: begin t = {1'b0, a} + {1'b0, ~b} + 5'd1; v = (a[3] != b[3]) && (t[3] != a[3]); end
            3'd2: begin t = {1'b0, b} + {1'b0, ~a} + 5'd1; v = (a[3] != b[3]) && (t[3] != b[3]); end
            3'd3: t = {1'b0, a & ~b};
            3'd4: t = {1'b0, a & b};
            3'd5: t = {1'b0, a | b};
            3'd6: t = {1'b0, a ^ b};
            default: t = {1'b0, ~(a ^ b)};
        endcase
        if (op <= 3'd2) c = t[4];
        return {t[3:0], t[3], (t[3:0] == 4'd0), c, v};
    endfunction

    always_comb begin
        {bus.alu_result, bus.alu_n, bus.alu_z, bus.alu_co, bus.alu_ovf} =
            alu_fn(bus.alu_control, bus.alu_srca, bus.alu_srcb);
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       id;
        logic [3:0] res;
        logic [3:0] rflags;
        logic [3:0] freg;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    logic       id_log[$];
    logic [3:0] mflags;
    logic [3:0] last_res;

    // Accept side: predict the response when a grant is seen.
    logic       a_sel, a_s;
    logic [2:0] a_op;
    logic [3:0] a_a, a_b, a_nzcv;
    logic [7:0] a_r;
    exp_t       a_e;
    always @(negedge clk) begin
        if (!reset && (bus.req0_ready || bus.req1_ready)) begin
            chk("single_ready", {31'b0, bus.req0_ready && bus.req1_ready}, 0);
            a_sel  = bus.req1_ready;
            a_op   = a_sel ? bus.req1_op : bus.req0_op;
            a_a    = a_sel ? bus.req1_a  : bus.req0_a;
            a_b    = a_sel ? bus.req1_b  : bus.req0_b;
            a_s    = a_sel ? bus.req1_s  : bus.req0_s;
            a_r    = alu_fn(a_op, a_a, a_b);
            a_nzcv = {a_r[3], a_r[2], (a_op <= 3'd2) ? a_r[1] : mflags[1],
                                      (a_op <= 3'd2) ? a_r[0] : mflags[0]};
            if (a_s) mflags = a_nzcv;
            a_e.id     = a_sel;
            a_e.res    = a_r[7:4];
            a_e.rflags = a_nzcv;
            a_e.freg   = mflags;
            a_e.acc    = cyc;
            sb.push_back(a_e);
        end
    end

    // Response side: check latency on rsp_valid rise, compare on handshake.
    logic prev_rv = 1'b0;
    exp_t r_e;
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && !prev_rv) begin
            if (sb.size() == 0) chk("rsp_unexpected", {31'b0, bus.rsp_valid}, 0);
            else                chk("latency", cyc - sb[0].acc, 2);
        end
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", {31'b0, bus.rsp_valid}, 0);
            end else begin
                r_e = sb.pop_front();
                chk("rsp_id",     {31'b0, bus.rsp_id}, {31'b0, r_e.id});
                chk("rsp_result", {28'b0, bus.rsp_result}, {28'b0, r_e.res});
                chk("rsp_flags",  {28'b0, bus.rsp_flags},  {28'b0, r_e.rflags});
                chk("flags_reg",  {28'b0, bus.flags},      {28'b0, r_e.freg});
                id_log.push_back(bus.rsp_id);
                last_res = bus.rsp_result;
            end
        end
        prev_rv = bus.rsp_valid;
    end

    task automatic set_req(input logic id, input logic [2:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic s);
        if (id) begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_s = s; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_s = s; bus.req0_valid = 1'b1;
        end
    endtask

    task automatic send(input logic id, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic s);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        set_req(id, op, a, b, s);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept_timeout", {31'b0, got}, 1);
        @(posedge clk); #1;
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.rsp_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_timeout", {31'b0, done}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int         c0, c1;
    bit         got;
    logic       h_id;
    logic [3:0] h_res, h_flg;

    initial begin
        reset = 1'b1;
        mflags = '0;
        last_res = '0;
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b0;
        bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_s = 1'b0;
        bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid",  {31'b0, bus.rsp_valid}, 0);
        chk("rst_rsp_id",     {31'b0, bus.rsp_id}, 0);
        chk("rst_rsp_result", {28'b0, bus.rsp_result}, 0);
        chk("rst_rsp_flags",  {28'b0, bus.rsp_flags}, 0);
        chk("rst_alu_ctrl",   {29'b0, bus.alu_control}, 0);
        chk("rst_srca",       {28'b0, bus.alu_srca}, 0);
        chk("rst_srcb",       {28'b0, bus.alu_srcb}, 0);
        chk("rst_flags",      {28'b0, bus.flags}, 0);
        chk("rst_ready0",     {31'b0, bus.req0_ready}, 0);
        chk("rst_ready1",     {31'b0, bus.req1_ready}, 0);
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Idle after reset
        repeat (5) begin
            @(negedge clk);
            chk("idle_flags",     {28'b0, bus.flags}, 0);
            chk("idle_rsp_valid", {31'b0, bus.rsp_valid}, 0);
            chk("idle_ready0",    {31'b0, bus.req0_ready}, 0);
            chk("idle_ready1",    {31'b0, bus.req1_ready}, 0);
        end

        // Both requesters at once: req0 first, req1 at the next IDLE
        @(posedge clk); #1;
        set_req(1'b0, 3'd5, 4'd3, 4'd4, 1'b0);
        set_req(1'b1, 3'd2, 4'd2, 4'd9, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin got = 1'b1; break; end
        end
        chk("rr_first_seen", {31'b0, got}, 1);
        chk("rr_first_r0",   {31'b0, bus.req0_ready}, 1);
        chk("rr_first_r1",   {31'b0, bus.req1_ready}, 0);
        c0 = cyc;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req1_ready) begin got = 1'b1; break; end
        end
        chk("rr_second_seen", {31'b0, got}, 1);
        c1 = cyc;
        chk("accept_spacing", c1 - c0, 3);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        drain();
        chk("id_log_size", id_log.size(), 2);
        if (id_log.size() == 2) begin
            chk("id_seq0", {31'b0, id_log[0]}, 0);
            chk("id_seq1", {31'b0, id_log[1]}, 1);
        end

        // ADD 7+1 with flag update
        send(1'b0, 3'd0, 4'd7, 4'd1, 1'b1);
        drain();
        chk("add_result", {28'b0, last_res}, 32'h8);
        chk("add_flags",  {28'b0, bus.flags}, 32'h9);

        // SUB to zero, AND keeps C/V, XOR without flag update
        send(1'b1, 3'd1, 4'd5, 4'd5, 1'b1);
        drain();
        chk("sub_result", {28'b0, last_res}, 32'h0);
        chk("sub_flags",  {28'b0, bus.flags}, 32'h6);
        send(1'b1, 3'd4, 4'hF, 4'h8, 1'b1);
        drain();
        chk("and_result", {28'b0, last_res}, 32'h8);
        chk("and_flags",  {28'b0, bus.flags}, 32'hA);
        send(1'b1, 3'd6, 4'd3, 4'd5, 1'b0);
        drain();
        chk("xor_result", {28'b0, last_res}, 32'h6);
        chk("xor_flags",  {28'b0, bus.flags}, 32'hA);

        // Response back-pressure with a competing request waiting
        bus.rsp_ready = 1'b0;
        send(1'b0, 3'd2, 4'd3, 4'd12, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin got = 1'b1; break; end
        end
        chk("bp_rsp_seen", {31'b0, got}, 1);
        h_id = bus.rsp_id; h_res = bus.rsp_result; h_flg = bus.rsp_flags;
        @(posedge clk); #1;
        set_req(1'b1, 3'd5, 4'd1, 4'd2, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid",  {31'b0, bus.rsp_valid}, 1);
            chk("bp_id",     {31'b0, bus.rsp_id}, {31'b0, h_id});
            chk("bp_result", {28'b0, bus.rsp_result}, {28'b0, h_res});
            chk("bp_flags",  {28'b0, bus.rsp_flags}, {28'b0, h_flg});
            chk("bp_ready0", {31'b0, bus.req0_ready}, 0);
            chk("bp_ready1", {31'b0, bus.req1_ready}, 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid_drop", {31'b0, bus.rsp_valid}, 0);
        chk("bp_next_grant", {31'b0, bus.req1_ready}, 1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        drain();

        // Reset while an s=1 op is in EXEC
        send(1'b0, 3'd0, 4'd7, 4'd1, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", {31'b0, bus.rsp_valid}, 0);
        chk("mid_rst_alu_ctrl",  {29'b0, bus.alu_control}, 0);
        chk("mid_rst_srca",      {28'b0, bus.alu_srca}, 0);
        chk("mid_rst_srcb",      {28'b0, bus.alu_srcb}, 0);
        chk("mid_rst_result",    {28'b0, bus.rsp_result}, 0);
        chk("mid_rst_flags",     {28'b0, bus.flags}, 0);
        sb.delete();
        mflags = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_valid", {31'b0, bus.rsp_valid}, 0);
            chk("post_rst_flags", {28'b0, bus.flags}, 0);
        end
        chk("post_rst_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
